div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 26 ++
 rtl/div_core.sv | 29 ++
 rtl/div_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the iterative divider: operand width, step count,
// FSM state encodings and a conditional two's-complement helper.
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = 5;

    // Counter value during the final shift-subtract step
    localparam logic [CNT_W-1:0] CNT_LAST = 5'(DIV_ITER - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                      input logic                 neg);
        if (neg) begin
            cond_neg = ~v + 32'd1;
        end else begin
            cond_neg = v;
        end
    endfunction

endpackage

// File: rtl/div_core.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder, trial-subtracts the divisor and shifts the resulting
// quotient bit into the low end of the dividend/quotient register.
module div_core
    import div_ctrl_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic [DIV_WIDTH-1:0] quo_i,
    input  logic [DIV_WIDTH-1:0] dvs_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic [DIV_WIDTH-1:0] quo_o
);

    logic [DIV_WIDTH:0] shift_s;
    logic               ge_s;

    // Trial subtraction; keep the difference only when it does not go negative
    always_comb begin
        shift_s = {rem_i, quo_i[DIV_WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, dvs_i});
        if (ge_s) begin
            rem_o = shift_s[DIV_WIDTH-1:0] - dvs_i;
        end else begin
            rem_o = shift_s[DIV_WIDTH-1:0];
        end
        quo_o = {quo_i[DIV_WIDTH-2:0], ge_s};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller for the EX stage: FSM, step counter, sign
// handling and result registers around the div_core datapath.
// Optional feature macro: DIV_EARLY_EXIT_EN (single-cycle CALC when the
// divisor is zero or the dividend magnitude is below the divisor magnitude).
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_div_req,
    input  logic                 es_valid,
    input  logic                 es_div_signed,
    input  logic [DIV_WIDTH-1:0] div_src1,
    input  logic [DIV_WIDTH-1:0] div_src2,
    input  logic                 flush,
    input  logic                 ms_allowin,
    output logic                 div_stop,
    output logic                 div_busy,
    output logic                 div_done,
    output logic [DIV_WIDTH-1:0] div_q,
    output logic [DIV_WIDTH-1:0] div_r
);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [DIV_WIDTH-1:0] res_q_q, res_q_d;
    logic [DIV_WIDTH-1:0] res_r_q, res_r_d;

    logic                 start_s;
    logic                 s1_neg_s;
    logic                 s2_neg_s;
    logic                 src_div0_s;
    logic [DIV_WIDTH-1:0] mag1_s;
    logic [DIV_WIDTH-1:0] mag2_s;
    logic [DIV_WIDTH-1:0] core_rem_s;
    logic [DIV_WIDTH-1:0] core_quo_s;
    logic                 last_step_s;
    logic [DIV_WIDTH-1:0] fin_q_raw_s;
    logic [DIV_WIDTH-1:0] fin_r_raw_s;
    logic [DIV_WIDTH-1:0] fin_q_s;
    logic [DIV_WIDTH-1:0] fin_r_s;

    div_core u_core (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (core_rem_s),
        .quo_o (core_quo_s)
    );

    // Decode a new request; a zero divisor keeps the raw dividend so the
    // remainder comes back unmodified and no sign correction is applied
    always_comb begin
        start_s    = resetn && (state_q == ST_IDLE) && es_div_req && es_valid && !flush;
        s1_neg_s   = es_div_signed && div_src1[DIV_WIDTH-1];
        s2_neg_s   = es_div_signed && div_src2[DIV_WIDTH-1];
        src_div0_s = (div_src2 == 32'd0);
        if (src_div0_s) begin
            mag1_s = div_src1;
        end else begin
            mag1_s = cond_neg(div_src1, s1_neg_s);
        end
        mag2_s = cond_neg(div_src2, s2_neg_s);
    end

`ifdef DIV_EARLY_EXIT_EN
    logic early_q, early_d;

    // Remember at start whether the quotient is trivially zero or all-ones
    always_comb begin
        if (start_s) begin
            early_d = src_div0_s || (mag1_s < mag2_s);
        end else begin
            early_d = early_q;
        end
    end

    // Early-exit flag register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            early_q <= 1'b0;
        end else begin
            early_q <= early_d;
        end
    end

    // Raw results: bypass values on the single early step, else the core output
    always_comb begin
        if (early_q) begin
            last_step_s = 1'b1;
            if (dvs_q == 32'd0) begin
                fin_q_raw_s = {DIV_WIDTH{1'b1}};
            end else begin
                fin_q_raw_s = {DIV_WIDTH{1'b0}};
            end
            fin_r_raw_s = quo_q;
        end else begin
            last_step_s = (cnt_q == CNT_LAST);
            fin_q_raw_s = core_quo_s;
            fin_r_raw_s = core_rem_s;
        end
    end
`else
    // Raw results come straight from the final shift-subtract step
    always_comb begin
        last_step_s = (cnt_q == CNT_LAST);
        fin_q_raw_s = core_quo_s;
        fin_r_raw_s = core_rem_s;
    end
`endif

    // Apply the sign correction latched at start
    always_comb begin
        fin_q_s = cond_neg(fin_q_raw_s, q_neg_q);
        fin_r_s = cond_neg(fin_r_raw_s, r_neg_q);
    end

    // FSM next state, datapath loading and result capture on CALC->DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_CALC;
                    cnt_d   = {CNT_W{1'b0}};
                    rem_d   = {DIV_WIDTH{1'b0}};
                    quo_d   = mag1_s;
                    dvs_d   = mag2_s;
                    q_neg_d = !src_div0_s && (s1_neg_s ^ s2_neg_s);
                    r_neg_d = !src_div0_s && s1_neg_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    rem_d = core_rem_s;
                    quo_d = core_quo_s;
                    if (last_step_s) begin
                        state_d = ST_DONE;
                        res_q_d = fin_q_s;
                        res_r_d = fin_r_s;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                if (flush || ms_allowin) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, datapath and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= {DIV_WIDTH{1'b0}};
            quo_q   <= {DIV_WIDTH{1'b0}};
            dvs_q   <= {DIV_WIDTH{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            res_q_q <= {DIV_WIDTH{1'b0}};
            res_r_q <= {DIV_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
        end
    end

    // Status and result outputs; the stall request is combinational for the hazard unit
    always_comb begin
        div_stop = !flush && (start_s || (state_q == ST_CALC));
        div_busy = (state_q != ST_IDLE);
        div_done = (state_q == ST_DONE);
        div_q    = res_q_q;
        div_r    = res_r_q;
    end

endmodule
